// File: rtl/fetch_pkg.sv
// Shared types and helpers for the byte-serial instruction fetch block.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered instruction together with the byte address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
  } q_entry_t;

  // Byte sequencer position inside the word being assembled (doubles as bcnt).
  typedef enum logic [1:0] {
    SEQ_B0 = 2'd0,
    SEQ_B1 = 2'd1,
    SEQ_B2 = 2'd2,
    SEQ_B3 = 2'd3
  } seq_state_t;

  function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the instruction-memory port, the redirect request and the decode handshake.
//
// Decode handshake: inst_valid/inst/inst_pc/inst_pc4 come from the fetch side;
// a word transfers on a rising clk edge where inst_valid && inst_ready are both 1.
// While inst_valid is 1 and inst_ready is 0 the payload holds still. inst_valid
// never depends on inst_ready. A redirect in the same cycle cancels the transfer.
interface fetch_if #(
  parameter int ADDR_W = 5
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic [BYTE_W-1:0] imem_rdata;
  logic              redir_valid;
  logic [INST_W-1:0] redir_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] inst_pc;
  logic [INST_W-1:0] inst_pc4;
  logic              misalign_err;
  seq_state_t        seq_state;   // debug view of the byte sequencer

  modport master (
    output imem_addr, inst_valid, inst, inst_pc, inst_pc4, misalign_err, seq_state,
    input  imem_rdata, redir_valid, redir_pc, inst_ready
  );

  modport slave (
    input  imem_addr, inst_valid, inst, inst_pc, inst_pc4, misalign_err, seq_state,
    output imem_rdata, redir_valid, redir_pc, inst_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched words; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     push,
  input  q_entry_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output q_entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  q_entry_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  // A push into a full queue is only legal when the head leaves in the same edge.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty && !flush;
    do_push = push && (!full || do_pop) && !flush;
    head    = empty ? '0 : mem[rd_ptr];
  end

  // Entry storage; needs no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles big-endian words from a byte-wide
// memory, queues them with their PC, and restarts on a branch/jump redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);

  seq_state_t  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [23:0] asm_q, asm_d;
  logic        misalign_q;

  logic        q_full;
  logic        q_empty;
  q_entry_t    q_head;
  q_entry_t    push_entry;
  logic        push;
  logic        pop;
  logic        space;

  // Byte sequencer next state, assembly shift and fetch-PC update; redirect wins.
  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    asm_d      = asm_q;
    push       = 1'b0;
    pop        = !q_empty && bus.inst_ready && !bus.redir_valid;
    space      = !q_full || (!q_empty && bus.inst_ready);
    push_entry = '{inst: {asm_q, bus.imem_rdata}, pc: fpc_q};
    if (bus.redir_valid) begin
      state_d = SEQ_B0;
      fpc_d   = {bus.redir_pc[31:2], 2'b00};
      asm_d   = '0;
    end else begin
      case (state_q)
        SEQ_B0: begin
          asm_d   = {asm_q[15:0], bus.imem_rdata};
          state_d = SEQ_B1;
        end
        SEQ_B1: begin
          asm_d   = {asm_q[15:0], bus.imem_rdata};
          state_d = SEQ_B2;
        end
        SEQ_B2: begin
          asm_d   = {asm_q[15:0], bus.imem_rdata};
          state_d = SEQ_B3;
        end
        default: begin
          // Last byte: complete only when the queue can take the word, else hold.
          if (space) begin
            push    = 1'b1;
            fpc_d   = pc_plus4(fpc_q);
            state_d = SEQ_B0;
          end
        end
      endcase
    end
  end

  // Sequencer, fetch PC, assembly register and misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SEQ_B0;
      fpc_q      <= RESET_PC;
      asm_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      asm_q      <= asm_d;
      misalign_q <= bus.redir_valid && (bus.redir_pc[1:0] != 2'b00);
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redir_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

  // Memory address and decode-side outputs; payload reads as zero when empty.
  always_comb begin
    bus.imem_addr    = fpc_q[ADDR_W-1:0] + ADDR_W'(state_q);
    bus.inst_valid   = !q_empty;
    bus.inst         = q_head.inst;
    bus.inst_pc      = q_head.pc;
    bus.inst_pc4     = q_empty ? '0 : pc_plus4(q_head.pc);
    bus.misalign_err = misalign_q;
    bus.seq_state    = state_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized ready/redirect/reset traffic checked cycle by cycle against a
// word-level model of the fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int QDEPTH = 2;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  fetch_if #(.ADDR_W(5)) bus();

  fetch_unit #(
    .ADDR_W  (5),
    .QDEPTH  (QDEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  logic [7:0] mem [32];
  always_comb bus.imem_rdata = mem[bus.imem_addr];

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Word stream: the fetch pointer plus a count of bytes already read; a full
  // word is taken straight from memory when its fourth byte is consumed.
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] m_fpc;
  int          m_bytes;
  logic        m_mis;
  bit          m_live = 0;

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [4:0] b;
    b = a[4:0];
    return {mem[b], mem[b + 5'd1], mem[b + 5'd2], mem[b + 5'd3]};
  endfunction

  // Compare on the falling edge, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    logic [31:0] e_inst, e_pc, e_pc4, e_addr;
    bit          popped;
    cyc++;
    if (m_live) begin
      e_inst = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      e_pc   = (exp_q.size() != 0) ? exp_pc_q[0] : 32'h0;
      e_pc4  = (exp_q.size() != 0) ? exp_pc_q[0] + 32'd4 : 32'h0;
      e_addr = (m_fpc + 32'(m_bytes)) & 32'h1F;
      chk("m_addr",  32'(bus.imem_addr), e_addr);
      chk("m_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
      chk("m_inst",  bus.inst, e_inst);
      chk("m_pc",    bus.inst_pc, e_pc);
      chk("m_pc4",   bus.inst_pc4, e_pc4);
      chk("m_mis",   32'(bus.misalign_err), 32'(m_mis));
    end
    if (reset) begin
      exp_q.delete();
      exp_pc_q.delete();
      m_fpc   = 32'h0;
      m_bytes = 0;
      m_mis   = 1'b0;
      m_live  = 1;
    end else if (m_live) begin
      if (bus.redir_valid) begin
        exp_q.delete();
        exp_pc_q.delete();
        m_fpc   = bus.redir_pc & 32'hFFFF_FFFC;
        m_bytes = 0;
        m_mis   = (bus.redir_pc[1:0] != 2'b00);
      end else begin
        m_mis  = 1'b0;
        popped = (exp_q.size() != 0) && bus.inst_ready;
        if (m_bytes < 3) begin
          m_bytes++;
          if (popped) begin
            void'(exp_q.pop_front());
            void'(exp_pc_q.pop_front());
          end
        end else begin
          if (popped) begin
            void'(exp_q.pop_front());
            void'(exp_pc_q.pop_front());
          end
          if (exp_q.size() < QDEPTH) begin
            exp_q.push_back(model_word(m_fpc));
            exp_pc_q.push_back(m_fpc);
            m_fpc   = m_fpc + 32'd4;
            m_bytes = 0;
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(0, 255));
    {mem[0], mem[1], mem[2], mem[3]}     = 32'h8C41_0004;
    {mem[4], mem[5], mem[6], mem[7]}     = 32'h1022_FFFE;
    {mem[8], mem[9], mem[10], mem[11]}   = 32'h1234_5678;
    {mem[28], mem[29], mem[30], mem[31]} = 32'hDEAD_BEEF;

    reset           = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    bus.inst_ready  = 1'b1;
    tick(); tick();
    reset = 1'b0;                                    // cycle 1
    chk("rst_addr",  32'(bus.imem_addr), 32'h0);
    chk("rst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst",  bus.inst, 32'h0);
    chk("rst_pc",    bus.inst_pc, 32'h0);
    chk("rst_pc4",   bus.inst_pc4, 32'h0);
    chk("rst_mis",   32'(bus.misalign_err), 32'h0);
    repeat (4) tick();                               // cycle 5
    chk("t1_valid", 32'(bus.inst_valid), 32'h1);
    chk("t1_inst0", bus.inst, 32'h8C41_0004);
    chk("t1_pc0",   bus.inst_pc, 32'h0);
    chk("t1_pc4_0", bus.inst_pc4, 32'h4);
    repeat (4) tick();                               // cycle 9
    chk("t1_inst1", bus.inst, 32'h1022_FFFE);
    chk("t1_pc1",   bus.inst_pc, 32'h4);
    chk("t1_pc4_1", bus.inst_pc4, 32'h8);

    // Back-pressure from reset: two words queue up, third holds on its last byte.
    reset          = 1'b1;
    bus.inst_ready = 1'b0;
    tick();
    reset = 1'b0;                                    // cycle 1
    repeat (20) tick();                              // cycle 21
    chk("t2_addr",  32'(bus.imem_addr), 32'h0B);
    chk("t2_seq",   32'(bus.seq_state), 32'(SEQ_B3));
    chk("t2_inst",  bus.inst, 32'h8C41_0004);
    chk("t2_pc",    bus.inst_pc, 32'h0);
    chk("t2_valid", 32'(bus.inst_valid), 32'h1);
    bus.inst_ready = 1'b1;                           // push and pop together
    tick();                                          // cycle 22
    chk("t3_inst", bus.inst, 32'h1022_FFFE);
    chk("t3_pc",   bus.inst_pc, 32'h4);
    chk("t3_addr", 32'(bus.imem_addr), 32'h0C);
    tick();                                          // cycle 23
    chk("t3_inst2", bus.inst, 32'h1234_5678);
    chk("t3_pc2",   bus.inst_pc, 32'h8);
    chk("t3_pc4_2", bus.inst_pc4, 32'hC);

    // Misaligned redirect while one word is queued and being accepted.
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h1E;
    tick();                                          // cycle 24
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    chk("t4_valid", 32'(bus.inst_valid), 32'h0);
    chk("t4_mis",   32'(bus.misalign_err), 32'h1);
    chk("t4_a0",    32'(bus.imem_addr), 32'h1C);
    tick();
    chk("t4_a1",    32'(bus.imem_addr), 32'h1D);
    chk("t4_mis0",  32'(bus.misalign_err), 32'h0);
    tick();
    chk("t4_a2",    32'(bus.imem_addr), 32'h1E);
    tick();
    chk("t4_a3",    32'(bus.imem_addr), 32'h1F);
    tick();                                          // cycle 28
    chk("t4_inst",  bus.inst, 32'hDEAD_BEEF);
    chk("t4_pc",    bus.inst_pc, 32'h1C);
    chk("t4_pc4",   bus.inst_pc4, 32'h20);
    chk("t5_a0",    32'(bus.imem_addr), 32'h0);
    tick();
    chk("t5_a1",    32'(bus.imem_addr), 32'h1);
    tick();
    chk("t5_a2",    32'(bus.imem_addr), 32'h2);
    tick();
    chk("t5_a3",    32'(bus.imem_addr), 32'h3);
    tick();                                          // cycle 32
    chk("t5_inst",  bus.inst, 32'h8C41_0004);
    chk("t5_pc",    bus.inst_pc, 32'h20);
    chk("t5_pc4",   bus.inst_pc4, 32'h24);
    tick(); tick();                                  // cycle 34, third byte of 0x24
    chk("t6_pre",   32'(bus.imem_addr), 32'h06);

    // Reset together with a misaligned redirect: reset must win.
    reset           = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc    = 32'h13;
    tick();                                          // cycle 35
    reset           = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc    = 32'h0;
    chk("t6_addr",  32'(bus.imem_addr), 32'h0);
    chk("t6_valid", 32'(bus.inst_valid), 32'h0);
    chk("t6_mis",   32'(bus.misalign_err), 32'h0);
    repeat (4) tick();                               // cycle 39
    chk("t6_valid1", 32'(bus.inst_valid), 32'h1);
    chk("t6_inst",   bus.inst, 32'h8C41_0004);
    chk("t6_pc",     bus.inst_pc, 32'h0);

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset           = ($urandom_range(0, 199) == 0);
      bus.redir_valid = ($urandom_range(0, 29) == 0);
      bus.redir_pc    = $urandom();
      bus.inst_ready  = ($urandom_range(0, 9) < 7);
    end
    tick();
    reset           = 1'b0;
    bus.redir_valid = 1'b0;
    bus.inst_ready  = 1'b1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage placed directly upstream of the single-cycle datapath's decode/control logic. The instruction memory is byte-wide (8 bits per location), so this block reads one byte per cycle. It assembles big-endian 32-bit instructions (lowest address → bits 31:24) and buffers them, with their PC and PC+4, in a small queue. Instructions are handed to decode over a valid/ready handshake, and a redirect input from the branch/jump logic flushes the block and restarts fetch.

Parameters:
ADDR_W, 5, instruction-memory byte-address width (32 locations)
QDEPTH, 2, instruction queue depth in words (power of two, ≥2)
RESET_PC, 32'h0, fetch address loaded on reset

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
imem_addr  out  ADDR_W  byte address to instruction memory
imem_rdata  in  8  byte read from imem_addr; combinational, same cycle
redir_valid  in  1  redirect request (taken branch/jump)
redir_pc  in  32  redirect target
inst_valid  out  1  queue head holds a valid instruction
inst_ready  in  1  decode accepts head this cycle
inst  out  32  instruction word at queue head
inst_pc  out  32  byte address of inst
inst_pc4  out  32  inst_pc + 4, modulo 2^32
misalign_err  out  1  one-cycle pulse: last redirect had redir_pc[1:0] != 0

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: fpc=RESET_PC, bcnt=0, assembly reg=0, queue empty, inst_valid=0, misalign_err=0. inst, inst_pc and inst_pc4 read as 0 while the queue is empty.
- State: fpc (32b fetch word address), bcnt (2b byte index), 24b assembly reg, queue with count 0..QDEPTH.
- imem_addr = (fpc + bcnt)[ADDR_W-1:0], combinational. Address aliases modulo 2^ADDR_W (fpc=0x20 reads byte 0).
- Bytes 0–2 (bcnt 0..2):
  - imem_rdata is shifted into the assembly reg and bcnt increments.
  - This happens regardless of queue occupancy.
- Byte 3 (bcnt==3): completes only if space = (count<QDEPTH) || pop.
  - On completion: push {asm,imem_rdata} with pc=fpc; fpc += 4 (wraps at 2^32); bcnt=0.
  - Without space: HOLD; bcnt stays 3, imem_addr is stable, nothing is pushed.
- pop = inst_valid && inst_ready. Push and pop in the same cycle leave count unchanged; push and pop at count==QDEPTH is legal.
- Queue outputs are registered from storage. A word pushed at edge N is visible, with inst_valid=1, in cycle N+1.
- Latency and throughput:
  - First instruction valid in the 5th cycle after reset deasserts.
  - Sustained throughput is 1 instruction per 4 cycles.
  - Back-pressure never drops or duplicates a word.
- Queue order is FIFO. inst, inst_pc and inst_pc4 are stable while inst_valid && !inst_ready.
- Redirect (redir_valid=1) has the highest priority in the cycle:
  - Flush queue (count=0), discard the partial assembly, bcnt=0, fpc={redir_pc[31:2],2'b00}.
  - Any push or pop in that cycle is cancelled; a pop with inst_ready=1 is not consumed.
  - inst_valid=0 next cycle; the target word is valid 4 cycles after that.
- misalign_err: registered; 1 for exactly the cycle after a redirect whose redir_pc[1:0]!=0, else 0.
- Reset during operation, including a simultaneous redirect: reset wins; all state returns to reset values next cycle.
- Back-to-back redirects: each restarts fetch; only the last target is fetched.

Decomposition:
- fetch_pkg:
  - Constants INST_W=32 and BYTE_W=8.
  - Default RESET_PC.
  - Queue entry typedef {inst[31:0], pc[31:0]}.
  - Function pc_plus4.
- Sub-module fetch_queue: synchronous FIFO of QDEPTH entries with push, pop, flush, full, empty, head. Flush has priority over push and pop.
- fetch_unit contains the byte sequencer, fpc/bcnt and redirect logic.

Test Plan:
1. imem bytes 0..7 = 8C 41 00 04 10 22 FF FE, inst_ready=1, release reset → cycle 5: inst=8C410004, inst_pc=0, inst_pc4=4; cycle 9: inst=1022FFFE, inst_pc=4, inst_pc4=8.
2. inst_ready=0 for 20 cycles → after 2 pushes, imem_addr holds at byte 3 of word 2 (addr 0x0B), count=2, head=8C410004 stable; raise ready → words 0, 1, 2 delivered in order, none lost.
3. Queue full, then inst_ready=1 in the same cycle bcnt==3 → push and pop both occur, count stays 2, head advances to 1022FFFE.
4. redir_valid=1, redir_pc=0x1E, while 1 word is queued and inst_ready=1 → next cycle inst_valid=0, misalign_err=1; imem_addr sequence 1C,1D,1E,1F; then inst_pc=0x1C.
5. fpc=0x1C word delivered → next fetch addresses 00..03 (alias); inst_pc=0x20, inst_pc4=0x24.
6. Assert reset mid-assembly (bcnt=2) together with redir_valid → next cycle imem_addr=RESET_PC[4:0], inst_valid=0, misalign_err=0; first instruction from RESET_PC 4 cycles later.
